// File: rtl/qupls_ptw_tran_buffer_pkg.sv
// rtl/qupls_ptw_tran_buffer_pkg.sv - types and constants shared by the PTW translation buffer
package qupls_ptw_tran_buffer_pkg;

  localparam int TBUF_SIZE = 16;
  localparam int PTW_TID_W = 5;
  localparam int PTW_ADR_W = 32;
  localparam int PTW_PTE_W = 64;

  typedef enum logic [1:0] {
    TB_FREE = 2'd0,
    TB_PEND = 2'd1,
    TB_OUT  = 2'd2,
    TB_DONE = 2'd3
  } ptw_tbuf_state_t;

  typedef struct packed {
    logic                 v;
    logic [5:0]           stk;
    logic [PTW_PTE_W-1:0] pte;
    logic                 err;
  } ptw_tran_buf_t;

  // Tag layout on the memory port: epoch in the MSB, entry index below it.
  function automatic logic [PTW_TID_W-1:0] ptw_make_tid(input logic epoch, input logic [3:0] idx);
    return {epoch, idx};
  endfunction

endpackage

// File: rtl/qupls_ptw_tran_buffer_if.sv
// rtl/qupls_ptw_tran_buffer_if.sv - walker memory port: tagged PTE read requests and responses
interface qupls_ptw_tran_buffer_if
  import qupls_ptw_tran_buffer_pkg::*;
#(
  parameter int ADR_W = PTW_ADR_W,
  parameter int PTE_W = PTW_PTE_W
);

  logic                 req_o;
  logic [ADR_W-1:0]     req_adr;
  logic [PTW_TID_W-1:0] req_tid;
  logic                 req_ack;
  logic                 resp_v;
  logic [PTW_TID_W-1:0] resp_tid;
  logic [PTE_W-1:0]     resp_dat;
  logic                 resp_err;

  modport master (
    output req_o, req_adr, req_tid,
    input  req_ack, resp_v, resp_tid, resp_dat, resp_err
  );

  modport slave (
    input  req_o, req_adr, req_tid,
    output req_ack, resp_v, resp_tid, resp_dat, resp_err
  );

endinterface

// File: rtl/qupls_ptw_ffo16.sv
// rtl/qupls_ptw_ffo16.sv - 16-bit find-first-one (lowest set bit), 6'h3f when no bit is set
module qupls_ptw_ffo16 (
  input  logic [15:0] i,
  output logic [5:0]  o
);

  always_comb begin
    o = 6'h3f;
    for (int n = 15; n >= 0; n--) begin
      if (i[n]) o = 6'(n);
    end
  end

endmodule

// File: rtl/qupls_ptw_tran_buffer.sv
// rtl/qupls_ptw_tran_buffer.sv - PTW translation buffer: walk request in, tagged PTE read out, translation back
module qupls_ptw_tran_buffer
  import qupls_ptw_tran_buffer_pkg::*;
#(
  parameter int ADR_W = PTW_ADR_W,
  parameter int PTE_W = PTW_PTE_W
)
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           walk_req,
  input  logic [5:0]                     walk_stk,
  input  logic [ADR_W-1:0]               walk_tadr,
  output logic                           walk_rdy,
  qupls_ptw_tran_buffer_if.master        mem,
  output ptw_tran_buf_t                  tranbuf [TBUF_SIZE],
  output logic [5:0]                     sel_tran,
  output logic                           stray,
  output logic [4:0]                     count
);

  ptw_tbuf_state_t st     [TBUF_SIZE];
  ptw_tbuf_state_t st_nxt [TBUF_SIZE];
  logic [ADR_W-1:0] adr   [TBUF_SIZE];

  logic             epoch;
  logic             iss_v;
  logic [3:0]       iss_idx;
  logic [15:0]      free_vec, pend_vec, done_vec;
  logic [5:0]       free_sel, pend_sel, done_sel;
  logic [3:0]       cur_idx;
  logic [3:0]       rsp_idx;
  logic             req_o_w;
  logic             alloc, ack_go, resp_ok, deliver;
  logic [4:0]       count_nxt;
  logic [PTE_W-1:0] rsp_pte;

  always_comb begin
    free_vec = '0;
    pend_vec = '0;
    done_vec = '0;
    for (int i = 0; i < TBUF_SIZE; i++) begin
      free_vec[i] = (st[i] == TB_FREE);
      pend_vec[i] = (st[i] == TB_PEND);
      done_vec[i] = (st[i] == TB_DONE);
    end
  end

  qupls_ptw_ffo16 u_free_sel (.i(free_vec), .o(free_sel));
  qupls_ptw_ffo16 u_pend_sel (.i(pend_vec), .o(pend_sel));
  qupls_ptw_ffo16 u_done_sel (.i(done_vec), .o(done_sel));

  assign walk_rdy = (free_sel != 6'h3f);
  assign sel_tran = done_sel;

  // Once an entry is presented it is held until acked, so a lower-index
  // allocation cannot change the request under the memory port's feet.
  assign cur_idx  = iss_v ? iss_idx : pend_sel[3:0];
  assign req_o_w  = iss_v || (pend_sel != 6'h3f);

  assign mem.req_o   = req_o_w;
  assign mem.req_adr = req_o_w ? adr[cur_idx] : '0;
  assign mem.req_tid = req_o_w ? ptw_make_tid(epoch, cur_idx) : '0;

  assign rsp_idx  = mem.resp_tid[3:0];
  assign rsp_pte  = mem.resp_err ? '0 : mem.resp_dat;

  // Each event targets an entry in a distinct state, so they never collide.
  assign alloc    = walk_req && walk_rdy;
  assign ack_go   = req_o_w && mem.req_ack;
  assign resp_ok  = mem.resp_v && (mem.resp_tid[4] == epoch) && (st[rsp_idx] == TB_OUT);
  assign deliver  = (done_sel != 6'h3f);

  always_comb begin
    st_nxt = st;
    if (flush) begin
      for (int i = 0; i < TBUF_SIZE; i++) st_nxt[i] = TB_FREE;
    end else begin
      if (alloc)   st_nxt[free_sel[3:0]] = TB_PEND;
      if (ack_go)  st_nxt[cur_idx]       = TB_OUT;
      if (resp_ok) st_nxt[rsp_idx]       = TB_DONE;
      if (deliver) st_nxt[done_sel[3:0]] = TB_FREE;
    end
  end

  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < TBUF_SIZE; i++) begin
      if (st_nxt[i] != TB_FREE) count_nxt = count_nxt + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TBUF_SIZE; i++) begin
        st[i]      <= TB_FREE;
        adr[i]     <= '0;
        tranbuf[i] <= '0;
      end
      epoch   <= 1'b0;
      iss_v   <= 1'b0;
      iss_idx <= '0;
      stray   <= 1'b0;
      count   <= '0;
    end else begin
      st    <= st_nxt;
      count <= count_nxt;
      stray <= mem.resp_v && !(resp_ok && !flush);
      if (flush) begin
        epoch <= ~epoch;
        iss_v <= 1'b0;
        for (int i = 0; i < TBUF_SIZE; i++) tranbuf[i].v <= 1'b0;
      end else begin
        iss_v   <= req_o_w && !mem.req_ack;
        iss_idx <= cur_idx;
        if (alloc) begin
          adr[free_sel[3:0]]         <= walk_tadr;
          tranbuf[free_sel[3:0]].stk <= walk_stk;
          tranbuf[free_sel[3:0]].err <= 1'b0;
        end
        if (resp_ok) begin
          tranbuf[rsp_idx].v   <= 1'b1;
          tranbuf[rsp_idx].pte <= rsp_pte;
          tranbuf[rsp_idx].err <= mem.resp_err;
        end
        if (deliver) tranbuf[done_sel[3:0]].v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qupls_ptw_tran_buffer.sv
// tb/tb_qupls_ptw_tran_buffer.sv - directed and randomized bench with a behavioural buffer model
module tb_qupls_ptw_tran_buffer;
  import qupls_ptw_tran_buffer_pkg::*;

  localparam int S_FREE = 0, S_PEND = 1, S_OUT = 2, S_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush, walk_req, walk_rdy, stray;
  logic [5:0]    walk_stk, sel_tran;
  logic [31:0]   walk_tadr;
  logic [4:0]    count;
  ptw_tran_buf_t tranbuf [TBUF_SIZE];

  qupls_ptw_tran_buffer_if #(.ADR_W(32), .PTE_W(64)) mem ();

  qupls_ptw_tran_buffer #(.ADR_W(32), .PTE_W(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .walk_req(walk_req), .walk_stk(walk_stk),
    .walk_tadr(walk_tadr), .walk_rdy(walk_rdy), .mem(mem), .tranbuf(tranbuf),
    .sel_tran(sel_tran), .stray(stray), .count(count)
  );

  always #5 clk = ~clk;

  // Model: per-entry lifecycle plus captured fields, and the tags handed to memory.
  int          ms    [16];
  logic [5:0]  m_stk [16];
  logic [31:0] m_adr [16];
  logic [63:0] m_pte [16];
  logic        m_err [16];
  logic        m_v   [16];
  logic        m_epoch, m_stray;
  int          m_cur;
  logic [4:0]  outq [$];
  int          n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input int s);
    for (int i = 0; i < 16; i++) if (ms[i] == s) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 16; i++) if (ms[i] != S_FREE) n++;
    return n;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      ms[i] = S_FREE; m_stk[i] = '0; m_adr[i] = '0; m_pte[i] = '0; m_err[i] = 0; m_v[i] = 0;
    end
    m_epoch = 0; m_stray = 0; m_cur = -1;
  endtask

  task automatic idle();
    flush = 0; walk_req = 0; walk_stk = '0; walk_tadr = '0;
    mem.req_ack = 0; mem.resp_v = 0; mem.resp_tid = '0; mem.resp_dat = '0; mem.resp_err = 0;
  endtask

  task automatic set_resp(input int idx, input logic [63:0] dat, input logic err);
    logic [4:0] t;
    t = {m_epoch, 4'(idx)};
    mem.resp_v = 1; mem.resp_tid = t; mem.resp_dat = dat; mem.resp_err = err;
    for (int k = outq.size() - 1; k >= 0; k--) if (outq[k] == t) outq.delete(k);
  endtask

  task automatic walk(input logic [5:0] stk, input logic [31:0] a);
    walk_req = 1; walk_stk = stk; walk_tadr = a;
  endtask

  // Check current outputs against the model, advance the model by this cycle's inputs, clock once.
  task automatic cycle();
    int  cur, lf, ld, ri;
    bit  take;
    cur = (m_cur >= 0) ? m_cur : lowest(S_PEND);
    lf  = lowest(S_FREE);
    ld  = lowest(S_DONE);
    check_eq("walk_rdy", walk_rdy, lf >= 0);
    check_eq("req_o", mem.req_o, cur >= 0);
    check_eq("req_adr", mem.req_adr, cur >= 0 ? m_adr[cur] : 0);
    check_eq("req_tid", mem.req_tid, cur >= 0 ? {m_epoch, 4'(cur)} : 0);
    check_eq("sel_tran", sel_tran, ld >= 0 ? ld : 63);
    check_eq("stray", stray, m_stray);
    check_eq("count", count, m_count());
    for (int i = 0; i < 16; i++) check_eq($sformatf("v%0d", i), tranbuf[i].v, m_v[i]);
    if (ld >= 0) begin
      check_eq("sel_stk", tranbuf[ld].stk, m_stk[ld]);
      check_eq("sel_pte", tranbuf[ld].pte, m_pte[ld]);
      check_eq("sel_err", tranbuf[ld].err, m_err[ld]);
    end
    if (flush) begin
      for (int i = 0; i < 16; i++) begin ms[i] = S_FREE; m_v[i] = 0; end
      m_epoch = ~m_epoch; m_cur = -1; m_stray = mem.resp_v;
    end else begin
      ri      = int'(mem.resp_tid[3:0]);
      take    = mem.resp_v && (mem.resp_tid[4] == m_epoch) && (ms[ri] == S_OUT);
      m_stray = mem.resp_v && !take;
      m_cur   = (cur >= 0 && !mem.req_ack) ? cur : -1;
      if (walk_req && lf >= 0) begin
        ms[lf] = S_PEND; m_stk[lf] = walk_stk; m_adr[lf] = walk_tadr; m_err[lf] = 0;
      end
      if (cur >= 0 && mem.req_ack) begin
        ms[cur] = S_OUT; outq.push_back({m_epoch, 4'(cur)});
      end
      if (take) begin
        ms[ri] = S_DONE; m_v[ri] = 1; m_err[ri] = mem.resp_err;
        m_pte[ri] = mem.resp_err ? 64'd0 : mem.resp_dat;
      end
      if (ld >= 0) begin ms[ld] = S_FREE; m_v[ld] = 0; end
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic drain();
    int n = 0;
    while ((m_count() != 0 || outq.size() != 0) && n < 400) begin
      mem.req_ack = 1;
      if (outq.size() != 0) begin
        mem.resp_v = 1; mem.resp_tid = outq.pop_front();
        mem.resp_dat = {$urandom, $urandom}; mem.resp_err = 0;
      end
      cycle();
      n++;
    end
    cycle();
    check_eq("drain_count", count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_walk_rdy", walk_rdy, 1);
    check_eq("rst_req_o", mem.req_o, 0);
    check_eq("rst_req_adr", mem.req_adr, 0);
    check_eq("rst_req_tid", mem.req_tid, 0);
    check_eq("rst_sel_tran", sel_tran, 6'h3f);
    check_eq("rst_stray", stray, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_tranbuf0", tranbuf[0], '0);
    rst = 0;

    // single walk
    walk(6'd3, 32'h0001_2340); cycle();
    check_eq("sw_req_o", mem.req_o, 1);
    check_eq("sw_req_tid", mem.req_tid, 5'h00);
    check_eq("sw_req_adr", mem.req_adr, 32'h0001_2340);
    mem.req_ack = 1; cycle();
    repeat (3) cycle();
    set_resp(0, 64'hABCD, 0); cycle();
    check_eq("sw_sel", sel_tran, 0);
    check_eq("sw_stk", tranbuf[0].stk, 3);
    check_eq("sw_pte", tranbuf[0].pte, 64'hABCD);
    cycle();
    check_eq("sw_v_clr", tranbuf[0].v, 0);
    check_eq("sw_count", count, 0);

    // fill
    for (int i = 0; i < 16; i++) begin walk(6'(i), 32'h1000 + 32'(i) * 16); cycle(); end
    check_eq("fill_rdy", walk_rdy, 0);
    check_eq("fill_count", count, 16);
    walk(6'h2a, 32'hDEAD_0000); cycle();
    check_eq("fill_drop_count", count, 16);
    check_eq("fill_req_adr", mem.req_adr, 32'h1000);
    drain();

    // out-of-order completion
    for (int i = 0; i < 3; i++) begin walk(6'(10 + i), 32'h2000 + 32'(i)); cycle(); end
    repeat (3) begin mem.req_ack = 1; cycle(); end
    set_resp(2, 64'h22, 0); cycle(); check_eq("ooo_sel_a", sel_tran, 2);
    set_resp(0, 64'h00, 0); cycle(); check_eq("ooo_sel_b", sel_tran, 0);
    set_resp(1, 64'h11, 0); cycle(); check_eq("ooo_sel_c", sel_tran, 1);
    cycle(); check_eq("ooo_count", count, 0);

    // flush with reads outstanding
    walk(6'd1, 32'h3000); cycle();
    walk(6'd2, 32'h3004); cycle();
    repeat (2) begin mem.req_ack = 1; cycle(); end
    flush = 1; cycle();
    check_eq("fl_count", count, 0);
    mem.resp_v = 1; mem.resp_tid = 5'h00; mem.resp_dat = 64'h1; cycle();
    check_eq("fl_stray_a", stray, 1);
    mem.resp_v = 1; mem.resp_tid = 5'h01; mem.resp_dat = 64'h2; cycle();
    check_eq("fl_stray_b", stray, 1);
    outq.delete();
    walk(6'd4, 32'h3008); cycle();
    check_eq("fl_new_tid", mem.req_tid, 5'h10);
    drain();

    // error response, then response to a pending entry
    walk(6'd7, 32'h4000); cycle();
    mem.req_ack = 1; cycle();
    set_resp(0, 64'h5555, 1); cycle();
    check_eq("err_sel", sel_tran, 0);
    check_eq("err_err", tranbuf[0].err, 1);
    check_eq("err_pte", tranbuf[0].pte, 0);
    cycle();
    walk(6'd8, 32'h4100); cycle();
    mem.resp_v = 1; mem.resp_tid = {m_epoch, 4'd0}; cycle();
    check_eq("pend_stray", stray, 1);
    check_eq("pend_req_o", mem.req_o, 1);
    drain();

    // simultaneous alloc / ack / response / delivery on four different entries
    for (int i = 0; i < 5; i++) begin walk(6'(20 + i), 32'h5000 + 32'(i)); cycle(); end
    repeat (5) begin mem.req_ack = 1; cycle(); end
    set_resp(1, 64'h101, 0); cycle();
    cycle();
    walk(6'd30, 32'h5100); set_resp(3, 64'h303, 0); cycle();
    walk(6'd31, 32'h5200); mem.req_ack = 1; set_resp(2, 64'h202, 0); cycle();
    check_eq("sim_sel", sel_tran, 2);
    check_eq("sim_req_tid", mem.req_tid, 5'h15);
    check_eq("sim_count", count, 5);
    check_eq("sim_v3", tranbuf[3].v, 0);
    drain();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      flush = ($urandom % 64) == 0;
      walk_req = $urandom % 2; walk_stk = 6'($urandom); walk_tadr = $urandom;
      mem.req_ack = $urandom % 2;
      if (outq.size() != 0 && ($urandom % 3) == 0) begin
        k = $urandom_range(0, outq.size() - 1);
        mem.resp_v = 1; mem.resp_tid = outq[k]; outq.delete(k);
        mem.resp_dat = {$urandom, $urandom}; mem.resp_err = ($urandom % 8) == 0;
      end else if (($urandom % 40) == 0) begin
        mem.resp_v = 1; mem.resp_tid = 5'($urandom); mem.resp_dat = {$urandom, $urandom};
      end
      cycle();
    end

    // asynchronous reset with traffic in flight; late responses must come back stray
    walk(6'd9, 32'h6000); cycle();
    mem.req_ack = 1; cycle();
    #2 rst = 1;
    #2;
    check_eq("arst_count", count, 0);
    check_eq("arst_req_o", mem.req_o, 0);
    check_eq("arst_sel", sel_tran, 6'h3f);
    check_eq("arst_rdy", walk_rdy, 1);
    rst = 0;
    m_reset();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
